// File: rtl/accel_wb_pkg.sv
// -----------------------------------------------------------------------------
// accel_wb_pkg
//
// Shared types for the two-master Wishbone arbiter in front of the
// accelerator slave port:
//   arb_state_e        - arbiter FSM state (idle, owned by m0/m1, abort cycle)
//   wb_req_t           - master-to-slave Wishbone request bundle
//   wb_rsp_t           - slave-to-master Wishbone response bundle
//   ABORT_DATA_DEFAULT - read data returned when the watchdog aborts an access
//   pick_owner()       - round-robin choice among requesting masters
// -----------------------------------------------------------------------------
package accel_wb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_GRANT0 = 2'd1,
    ST_GRANT1 = 2'd2,
    ST_ABORT  = 2'd3
  } arb_state_e;

  typedef struct packed {
    logic        cyc;
    logic        stb;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] adr;
    logic [31:0] dat;
  } wb_req_t;

  typedef struct packed {
    logic        ack;
    logic [31:0] dat;
  } wb_rsp_t;

  localparam logic [31:0] ABORT_DATA_DEFAULT = 32'hDEAD_BEEF;

  // Round-robin choice: a lone requester wins outright; on a tie the master
  // that was not granted last wins. No requester means the bus goes idle.
  function automatic arb_state_e pick_owner(input logic [1:0] cyc,
                                            input logic       last);
    arb_state_e st;
    st = ST_IDLE;
    if (cyc == 2'b11) begin
      st = last ? ST_GRANT0 : ST_GRANT1;
    end else if (cyc[0]) begin
      st = ST_GRANT0;
    end else if (cyc[1]) begin
      st = ST_GRANT1;
    end
    return st;
  endfunction

endpackage : accel_wb_pkg

// File: rtl/accel_wb_watchdog.sv
// -----------------------------------------------------------------------------
// accel_wb_watchdog
//
// Cycle counter used to detect a slave that never acknowledges a strobed
// access. It counts while en_i is high, returns to zero whenever clr_i is
// high, and flags expired_o once the count equals TIMEOUT. The count stops
// at TIMEOUT so it can never wrap back to a small value.
//
// Ports:
//   clk_i     - clock
//   rst_ni    - asynchronous active-low reset
//   clr_i     - synchronous clear (has priority over en_i)
//   en_i      - count enable
//   expired_o - count has reached TIMEOUT
// -----------------------------------------------------------------------------
module accel_wb_watchdog
  import accel_wb_pkg::*;
#(
  parameter int unsigned TIMEOUT   = 255,
  parameter int unsigned TIMEOUT_W = 8
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam logic [TIMEOUT_W-1:0] LIMIT = TIMEOUT_W'(TIMEOUT);
  localparam logic [TIMEOUT_W-1:0] ONE   = TIMEOUT_W'(1);

  logic [TIMEOUT_W-1:0] cnt_q;
  logic [TIMEOUT_W-1:0] cnt_d;

  assign expired_o = (cnt_q == LIMIT);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && !expired_o) begin
      cnt_d = cnt_q + ONE;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule : accel_wb_watchdog

// File: rtl/accel_wb_arbiter.sv
// -----------------------------------------------------------------------------
// accel_wb_arbiter
//
// Shares the accelerator's single Wishbone slave port between the management
// SoC (master 0) and a second on-chip master (master 1). Ownership is granted
// round-robin and held for a whole bus cycle (cyc). While a master owns the
// bus its request is passed straight through to the slave and the slave's
// ack/data straight back, so the slave's ack latency is preserved. A watchdog
// aborts an access that waits TIMEOUT cycles for ack: the owner receives one
// ack carrying ABORT_DATA and the sticky timeout flag is raised.
//
// Ports:
//   wb_clk_i, wb_rst_ni          - clock, asynchronous active-low reset
//   m0_* / m1_*                  - master-side Wishbone (cyc/stb/we/sel/adr/dat
//                                  in, ack/dat out)
//   s_*                          - accelerator slave-side Wishbone
//   grant_o                      - one-hot current owner, 2'b00 when idle
//   timeout_o / timeout_clr_i    - sticky abort flag and its clear
// -----------------------------------------------------------------------------
module accel_wb_arbiter
  import accel_wb_pkg::*;
#(
  parameter int unsigned TIMEOUT    = 255,
  parameter int unsigned TIMEOUT_W  = 8,
  parameter logic [31:0] ABORT_DATA = ABORT_DATA_DEFAULT
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_ni,
  // master 0
  input  logic        m0_cyc_i,
  input  logic        m0_stb_i,
  input  logic        m0_we_i,
  input  logic [3:0]  m0_sel_i,
  input  logic [31:0] m0_adr_i,
  input  logic [31:0] m0_dat_i,
  output logic        m0_ack_o,
  output logic [31:0] m0_dat_o,
  // master 1
  input  logic        m1_cyc_i,
  input  logic        m1_stb_i,
  input  logic        m1_we_i,
  input  logic [3:0]  m1_sel_i,
  input  logic [31:0] m1_adr_i,
  input  logic [31:0] m1_dat_i,
  output logic        m1_ack_o,
  output logic [31:0] m1_dat_o,
  // accelerator slave
  output logic        s_cyc_o,
  output logic        s_stb_o,
  output logic        s_we_o,
  output logic [3:0]  s_sel_o,
  output logic [31:0] s_adr_o,
  output logic [31:0] s_dat_o,
  input  logic        s_ack_i,
  input  logic [31:0] s_dat_i,
  // status
  output logic [1:0]  grant_o,
  output logic        timeout_o,
  input  logic        timeout_clr_i
);

  wb_req_t [1:0] m_req;
  wb_rsp_t [1:0] m_rsp;
  wb_req_t       own_req;
  wb_req_t       s_req;

  arb_state_e state_q, state_d;
  logic       last_q, last_d;
  logic       timeout_q, timeout_d;

  logic       owner;
  logic [1:0] owner_mask;
  logic [1:0] cyc_vec;
  logic       in_grant;
  logic       wd_en;
  logic       wd_clr;
  logic       wd_expired;
  logic [1:0] grant;

  assign m_req[0] = '{cyc: m0_cyc_i, stb: m0_stb_i, we: m0_we_i,
                      sel: m0_sel_i, adr: m0_adr_i, dat: m0_dat_i};
  assign m_req[1] = '{cyc: m1_cyc_i, stb: m1_stb_i, we: m1_we_i,
                      sel: m1_sel_i, adr: m1_adr_i, dat: m1_dat_i};

  assign cyc_vec = {m1_cyc_i, m0_cyc_i};

  // In ABORT the state no longer names the owner; last_q still does, because
  // it was written on entry to the GRANT state that is being aborted.
  assign owner      = (state_q == ST_GRANT1) || ((state_q == ST_ABORT) && last_q);
  assign owner_mask = owner ? 2'b10 : 2'b01;
  assign own_req    = m_req[owner];
  assign in_grant   = (state_q == ST_GRANT0) || (state_q == ST_GRANT1);

  // Count only while the owner is strobing and the slave stays silent; any
  // state change (handover, abort, return from abort) restarts the count.
  assign wd_en  = in_grant && own_req.stb && !s_ack_i;
  assign wd_clr = !wd_en || (state_d != state_q);

  accel_wb_watchdog #(
    .TIMEOUT   (TIMEOUT),
    .TIMEOUT_W (TIMEOUT_W)
  ) u_watchdog (
    .clk_i     (wb_clk_i),
    .rst_ni    (wb_rst_ni),
    .clr_i     (wd_clr),
    .en_i      (wd_en),
    .expired_o (wd_expired)
  );

  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    timeout_d = timeout_q;

    unique case (state_q)
      ST_IDLE: begin
        state_d = pick_owner(cyc_vec, last_q);
      end
      ST_GRANT0, ST_GRANT1: begin
        if (!own_req.cyc) begin
          // Owner released the bus: a waiting master takes over with no bubble.
          state_d = pick_owner(cyc_vec & ~owner_mask, last_q);
        end else if (wd_en && wd_expired) begin
          state_d = ST_ABORT;
        end
      end
      ST_ABORT: begin
        if (own_req.cyc) begin
          state_d = owner ? ST_GRANT1 : ST_GRANT0;
        end else begin
          state_d = pick_owner(cyc_vec & ~owner_mask, last_q);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (state_d == ST_GRANT0) begin
      last_d = 1'b0;
    end else if (state_d == ST_GRANT1) begin
      last_d = 1'b1;
    end

    // A new abort outranks a clear requested in the same cycle.
    if (state_d == ST_ABORT) begin
      timeout_d = 1'b1;
    end else if (timeout_clr_i) begin
      timeout_d = 1'b0;
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q   <= ST_IDLE;
      last_q    <= 1'b1;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      timeout_q <= timeout_d;
    end
  end

  // Output muxing is purely a function of the registered state, so the
  // asynchronous reset forces every output to zero immediately.
  always_comb begin
    s_req = '0;
    m_rsp = '0;
    grant = 2'b00;

    unique case (state_q)
      ST_GRANT0, ST_GRANT1: begin
        s_req        = own_req;
        m_rsp[owner] = '{ack: s_ack_i, dat: s_dat_i};
        grant        = owner_mask;
      end
      ST_ABORT: begin
        m_rsp[owner] = '{ack: 1'b1, dat: ABORT_DATA};
        grant        = owner_mask;
      end
      default: begin
      end
    endcase
  end

  assign s_cyc_o   = s_req.cyc;
  assign s_stb_o   = s_req.stb;
  assign s_we_o    = s_req.we;
  assign s_sel_o   = s_req.sel;
  assign s_adr_o   = s_req.adr;
  assign s_dat_o   = s_req.dat;

  assign m0_ack_o  = m_rsp[0].ack;
  assign m0_dat_o  = m_rsp[0].dat;
  assign m1_ack_o  = m_rsp[1].ack;
  assign m1_dat_o  = m_rsp[1].dat;

  assign grant_o   = grant;
  assign timeout_o = timeout_q;

endmodule : accel_wb_arbiter

// File: tb/tb_accel_wb_arbiter.sv
module tb_accel_wb_arbiter;

  localparam int          TO  = 4;
  localparam logic [31:0] ABD = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  m_cyc, m_stb, m_we;
  logic [3:0]  m_sel  [2];
  logic [31:0] m_adr  [2];
  logic [31:0] m_wdat [2];
  logic        s_ack;
  logic [31:0] s_rdat;
  logic        tclr;

  logic        m0_ack, m1_ack;
  logic [31:0] m0_rd, m1_rd;
  logic        s_cyc, s_stb, s_we;
  logic [3:0]  s_sel;
  logic [31:0] s_adr, s_wd;
  logic [1:0]  grant;
  logic        tout;

  always #5 clk = ~clk;

  accel_wb_arbiter #(
    .TIMEOUT    (TO),
    .TIMEOUT_W  (8),
    .ABORT_DATA (ABD)
  ) dut (
    .wb_clk_i      (clk),
    .wb_rst_ni     (rst_n),
    .m0_cyc_i      (m_cyc[0]),
    .m0_stb_i      (m_stb[0]),
    .m0_we_i       (m_we[0]),
    .m0_sel_i      (m_sel[0]),
    .m0_adr_i      (m_adr[0]),
    .m0_dat_i      (m_wdat[0]),
    .m0_ack_o      (m0_ack),
    .m0_dat_o      (m0_rd),
    .m1_cyc_i      (m_cyc[1]),
    .m1_stb_i      (m_stb[1]),
    .m1_we_i       (m_we[1]),
    .m1_sel_i      (m_sel[1]),
    .m1_adr_i      (m_adr[1]),
    .m1_dat_i      (m_wdat[1]),
    .m1_ack_o      (m1_ack),
    .m1_dat_o      (m1_rd),
    .s_cyc_o       (s_cyc),
    .s_stb_o       (s_stb),
    .s_we_o        (s_we),
    .s_sel_o       (s_sel),
    .s_adr_o       (s_adr),
    .s_dat_o       (s_wd),
    .s_ack_i       (s_ack),
    .s_dat_i       (s_rdat),
    .grant_o       (grant),
    .timeout_o     (tout),
    .timeout_clr_i (tclr)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model: who owns the bus (-1 = nobody), whether this cycle is the
  // single abort cycle, who was granted last, how long the owner's current
  // strobe has gone unanswered, and the sticky timeout flag.
  int mo    = -1;
  bit mab   = 1'b0;
  int mlast = 1;
  int mwait = 0;
  bit mto   = 1'b0;

  task automatic model_reset();
    mo = -1; mab = 1'b0; mlast = 1; mwait = 0; mto = 1'b0;
  endtask

  function automatic int pick(input logic c0, input logic c1);
    if (c0 && c1) return (mlast == 1) ? 0 : 1;
    if (c0) return 0;
    if (c1) return 1;
    return -1;
  endfunction

  // Advance the model by one clock using the inputs held across the edge.
  task automatic model_step();
    int nxt;
    bit set_to;
    bit keep;
    set_to = 1'b0;
    keep   = 1'b0;
    if (!rst_n) begin
      model_reset();
      return;
    end
    if (mab) begin
      mab = 1'b0;
      nxt = m_cyc[mo] ? mo : pick(mo == 0 ? 1'b0 : m_cyc[0], mo == 1 ? 1'b0 : m_cyc[1]);
    end else if (mo < 0) begin
      nxt = pick(m_cyc[0], m_cyc[1]);
    end else if (!m_cyc[mo]) begin
      nxt = pick(mo == 0 ? 1'b0 : m_cyc[0], mo == 1 ? 1'b0 : m_cyc[1]);
    end else if (m_stb[mo] && !s_ack && mwait == TO) begin
      nxt = mo; mab = 1'b1; set_to = 1'b1;
    end else begin
      nxt = mo; keep = 1'b1;
    end
    if (keep && m_stb[mo] && !s_ack) mwait++;
    else mwait = 0;
    if (set_to) mto = 1'b1;
    else if (tclr) mto = 1'b0;
    if (nxt >= 0) mlast = nxt;
    mo = nxt;
  endtask

  task automatic compare_all();
    logic [1:0]  e_ack, e_grant;
    logic [31:0] e_rd [2];
    logic        e_cyc, e_stb, e_we;
    logic [3:0]  e_sel;
    logic [31:0] e_adr, e_wd;
    e_ack = 2'b00; e_grant = 2'b00; e_rd[0] = '0; e_rd[1] = '0;
    e_cyc = 1'b0; e_stb = 1'b0; e_we = 1'b0; e_sel = '0; e_adr = '0; e_wd = '0;
    if (mab) begin
      e_ack[mo] = 1'b1;
      e_rd[mo]  = ABD;
    end else if (mo >= 0) begin
      e_cyc = m_cyc[mo]; e_stb = m_stb[mo]; e_we = m_we[mo];
      e_sel = m_sel[mo]; e_adr = m_adr[mo]; e_wd = m_wdat[mo];
      e_ack[mo]   = s_ack;
      e_rd[mo]    = s_rdat;
      e_grant[mo] = 1'b1;
    end
    chk("m0_ack", 32'(m0_ack), 32'(e_ack[0]));
    chk("m1_ack", 32'(m1_ack), 32'(e_ack[1]));
    chk("m0_dat", m0_rd, e_rd[0]);
    chk("m1_dat", m1_rd, e_rd[1]);
    chk("s_cyc", 32'(s_cyc), 32'(e_cyc));
    chk("s_stb", 32'(s_stb), 32'(e_stb));
    chk("timeout", 32'(tout), 32'(mto));
    if (!mab) begin
      chk("grant", 32'(grant), 32'(e_grant));
      chk("s_we", 32'(s_we), 32'(e_we));
      chk("s_sel", 32'(s_sel), 32'(e_sel));
      chk("s_adr", s_adr, e_adr);
      chk("s_dat", s_wd, e_wd);
    end
  endtask

  task automatic idle_inputs();
    m_cyc = 2'b00; m_stb = 2'b00; m_we = 2'b00;
    for (int i = 0; i < 2; i++) begin
      m_sel[i] = '0; m_adr[i] = '0; m_wdat[i] = '0;
    end
    s_ack = 1'b0; s_rdat = '0; tclr = 1'b0;
  endtask

  task automatic settle();
    #1;
    compare_all();
  endtask

  task automatic adv();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    idle_inputs();
    #1;
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_s_cyc", 32'(s_cyc), 32'd0);
    chk("rst_timeout", 32'(tout), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    bit hung;
    idle_inputs();
    @(negedge clk);
    do_reset();

    // Single master write, slave acks 2 cycles after stb.
    m_cyc[0] = 1'b1; m_stb[0] = 1'b1; m_we[0] = 1'b1; m_sel[0] = 4'hF;
    m_adr[0] = 32'h3200_0004; m_wdat[0] = 32'h0000_1234;
    settle();
    chk("arb_latency_idle", 32'(s_cyc), 32'd0);
    adv();
    settle();
    chk("arb_latency_cyc", 32'(s_cyc), 32'd1);
    chk("single_grant", 32'(grant), 32'h1);
    chk("single_adr", s_adr, 32'h3200_0004);
    chk("single_wdat", s_wd, 32'h0000_1234);
    adv();
    settle();
    adv();
    s_ack = 1'b1;
    settle();
    chk("single_ack_pass", 32'(m0_ack), 32'd1);
    adv();
    s_ack = 1'b0; m_cyc[0] = 1'b0; m_stb[0] = 1'b0;
    settle();
    adv();
    settle();
    chk("single_idle", 32'(grant), 32'd0);
    adv();

    // Contention from reset: m0 first, handover without bubble, then m0 again.
    do_reset();
    m_cyc = 2'b11;
    settle();
    adv();
    settle();
    chk("cont_first", 32'(grant), 32'h1);
    m_cyc[0] = 1'b0;
    settle();
    adv();
    settle();
    chk("cont_handover", 32'(grant), 32'h2);
    m_cyc[1] = 1'b0;
    settle();
    adv();
    m_cyc = 2'b11;
    settle();
    chk("cont_idle", 32'(grant), 32'd0);
    adv();
    settle();
    chk("cont_rr_second", 32'(grant), 32'h1);
    m_cyc = 2'b00;
    settle();
    adv();
    settle();
    adv();

    // Hold: three stb pulses from m1 under one cyc while m0 waits.
    m_cyc = 2'b10;
    settle();
    adv();
    settle();
    chk("hold_grant", 32'(grant), 32'h2);
    m_cyc[0] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      m_stb[1] = 1'b1; m_adr[1] = $urandom; s_ack = 1'b1; s_rdat = $urandom;
      settle();
      chk("hold_grant_ack", 32'(grant), 32'h2);
      chk("hold_m1_ack", 32'(m1_ack), 32'd1);
      chk("hold_m1_dat", m1_rd, s_rdat);
      adv();
      m_stb[1] = 1'b0; s_ack = 1'b0;
      settle();
      chk("hold_grant_gap", 32'(grant), 32'h2);
      adv();
    end
    m_cyc[1] = 1'b0;
    settle();
    adv();
    settle();
    chk("hold_release", 32'(grant), 32'h1);
    m_cyc = 2'b00;
    settle();
    adv();
    settle();
    adv();

    // Timeout: m0 read that is never acked.
    m_cyc[0] = 1'b1; m_we[0] = 1'b0; m_adr[0] = 32'h3200_0010;
    settle();
    adv();
    m_stb[0] = 1'b1;
    for (int k = 0; k < TO + 1; k++) begin
      settle();
      chk("to_wait_ack", 32'(m0_ack), 32'd0);
      chk("to_wait_stb", 32'(s_stb), 32'd1);
      adv();
    end
    settle();
    chk("to_abort_ack", 32'(m0_ack), 32'd1);
    chk("to_abort_dat", m0_rd, 32'hDEAD_BEEF);
    chk("to_abort_stb", 32'(s_stb), 32'd0);
    chk("to_flag", 32'(tout), 32'd1);
    adv();
    m_cyc[0] = 1'b0; m_stb[0] = 1'b0;
    settle();
    adv();
    tclr = 1'b1;
    settle();
    adv();
    tclr = 1'b0;
    settle();
    chk("to_cleared", 32'(tout), 32'd0);
    adv();

    // Reset asserted mid-access while m1 has a strobe pending.
    m_cyc[1] = 1'b1; m_stb[1] = 1'b1;
    settle();
    adv();
    settle();
    chk("rstmid_grant", 32'(grant), 32'h2);
    #1 rst_n = 1'b0;
    #1;
    chk("rstmid_s_cyc", 32'(s_cyc), 32'd0);
    chk("rstmid_s_stb", 32'(s_stb), 32'd0);
    chk("rstmid_grant0", 32'(grant), 32'd0);
    s_ack = 1'b1;
    #1;
    chk("rstmid_no_ack", 32'(m1_ack), 32'd0);
    model_reset();
    idle_inputs();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    m_cyc = 2'b11;
    settle();
    adv();
    settle();
    chk("rstmid_after", 32'(grant), 32'h1);
    m_cyc = 2'b00;
    settle();
    adv();

    // Randomized traffic, including hung-slave stretches and random clears.
    hung = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < 2; i++) begin
        if ($urandom_range(7) == 0) m_cyc[i] = ~m_cyc[i];
        m_stb[i]  = m_cyc[i] & ($urandom_range(1) == 1);
        m_we[i]   = 1'($urandom_range(1));
        m_sel[i]  = 4'($urandom);
        m_adr[i]  = $urandom;
        m_wdat[i] = $urandom;
      end
      if ($urandom_range(19) == 0) hung = ~hung;
      s_ack  = !hung && ($urandom_range(2) == 0);
      s_rdat = $urandom;
      tclr   = ($urandom_range(15) == 0);
      settle();
      adv();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_accel_wb_arbiter
